servo_pwm_gen: RTL and testbench

- Consumer end of the servo_angle_gen interface: takes the 12-bit angle/valid outputs of the three leg solvers (channels 0/1/2 = beta 90/210/330) and drives three hobby-servo PWM lines.
- Shared frame counter; per-channel pipelined angle-to-pulse-width conversion; double-buffered widths.
- New values commit only at frame boundaries, so no pulse is ever truncated or stretched mid-frame.

---
 rtl/servo_pwm_gen.sv | 129 ++++++++++++
 tb/tb_servo_pwm_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// Three-channel hobby-servo PWM generator: shared frame counter, two-stage
// angle-to-width conversion per channel, widths committed only at frame boundaries.
module servo_pwm_gen #(
  parameter int unsigned PERIOD_TICKS  = 2000000,
  parameter int unsigned PULSE_MIN     = 50000,
  parameter int unsigned TICKS_PER_LSB = 111,
  parameter int unsigned ANGLE_MAX     = 1800,
  parameter int unsigned ANGLE_RESET   = 900
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] angle0,
  input  logic [11:0] angle1,
  input  logic [11:0] angle2,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        valid2,
  output logic        pwm0,
  output logic        pwm1,
  output logic        pwm2,
  output logic        frame_start,
  output logic [2:0]  pending,
  output logic [2:0]  clamped
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned ANG_W = 12;
  localparam int unsigned CNT_W = $clog2(PERIOD_TICKS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] WIDTH_RST = CNT_W'(PULSE_MIN + ANGLE_RESET * TICKS_PER_LSB);
  localparam logic [ANG_W-1:0] ANG_MAX   = ANG_W'(ANGLE_MAX);

  // Widths always fit the counter because every legal width is below PERIOD_TICKS.
  function automatic logic [CNT_W-1:0] angle_to_width(input logic [ANG_W-1:0] a);
    return CNT_W'(PULSE_MIN + 32'(a) * TICKS_PER_LSB);
  endfunction

  logic [NCH-1:0][ANG_W-1:0] angle_in;
  logic [NCH-1:0]            valid_in;

  assign angle_in = {angle2, angle1, angle0};
  assign valid_in = {valid2, valid1, valid0};

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      frame_q, frame_d;
  logic [NCH-1:0]            pwm_q, pwm_d;
  logic [NCH-1:0]            s1_vld_q, s1_vld_d;
  logic [NCH-1:0][ANG_W-1:0] ang_q, ang_d;
  logic [NCH-1:0]            clamped_q, clamped_d;
  logic [NCH-1:0]            pending_q, pending_d;
  logic [NCH-1:0][CNT_W-1:0] wpend_q, wpend_d;
  logic [NCH-1:0][CNT_W-1:0] wact_q, wact_d;
  logic                      boundary;

  // Next-state: frame counter, output compare, conversion pipeline and commit.
  always_comb begin
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    pwm_d     = pwm_q;
    s1_vld_d  = s1_vld_q;
    ang_d     = ang_q;
    clamped_d = clamped_q;
    pending_d = pending_q;
    wpend_d   = wpend_q;
    wact_d    = wact_q;

    boundary = (cnt_q == CNT_LAST);
    cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
    frame_d  = (cnt_q == '0);

    for (int unsigned n = 0; n < NCH; n++) begin
      pwm_d[n]    = (cnt_q < wact_q[n]);
      s1_vld_d[n] = valid_in[n];

      if (valid_in[n]) begin
        if (angle_in[n] > ANG_MAX) begin
          ang_d[n]     = ANG_MAX;
          clamped_d[n] = 1'b1;
        end else begin
          ang_d[n] = angle_in[n];
        end
      end

      if (boundary && pending_q[n]) begin
        wact_d[n]    = wpend_q[n];
        pending_d[n] = 1'b0;
      end

      // A stage-2 write on the commit edge lands after the commit and stays pending.
      if (s1_vld_q[n]) begin
        wpend_d[n]   = angle_to_width(ang_q[n]);
        pending_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      frame_q   <= 1'b0;
      pwm_q     <= '0;
      s1_vld_q  <= '0;
      ang_q     <= '0;
      clamped_q <= '0;
      pending_q <= '0;
      wpend_q   <= {NCH{WIDTH_RST}};
      wact_q    <= {NCH{WIDTH_RST}};
    end else begin
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      pwm_q     <= pwm_d;
      s1_vld_q  <= s1_vld_d;
      ang_q     <= ang_d;
      clamped_q <= clamped_d;
      pending_q <= pending_d;
      wpend_q   <= wpend_d;
      wact_q    <= wact_d;
    end
  end

  assign pwm0        = pwm_q[0];
  assign pwm1        = pwm_q[1];
  assign pwm2        = pwm_q[2];
  assign frame_start = frame_q;
  assign pending     = pending_q;
  assign clamped     = clamped_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: a frame-level reference model predicts each
// frame's pulse width per channel; a monitor measures pulses and compares.
module tb_servo_pwm_gen;

  localparam int P     = 4000;
  localparam int PM    = 100;
  localparam int TPL   = 1;
  localparam int AMAX  = 1800;
  localparam int AR    = 900;
  localparam int W_RST = PM + AR * TPL;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] ang [3];
  logic [2:0]  vld = '0;
  logic        pwm0, pwm1, pwm2, frame_start;
  logic [2:0]  pending, clamped;
  logic [2:0]  pwm_w;

  assign pwm_w = {pwm2, pwm1, pwm0};

  always #5 clock = ~clock;

  servo_pwm_gen #(
    .PERIOD_TICKS (P),
    .PULSE_MIN    (PM),
    .TICKS_PER_LSB(TPL),
    .ANGLE_MAX    (AMAX),
    .ANGLE_RESET  (AR)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .angle0     (ang[0]),
    .angle1     (ang[1]),
    .angle2     (ang[2]),
    .valid0     (vld[0]),
    .valid1     (vld[1]),
    .valid2     (vld[2]),
    .pwm0       (pwm0),
    .pwm1       (pwm1),
    .pwm2       (pwm2),
    .frame_start(frame_start),
    .pending    (pending),
    .clamped    (clamped)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. k counts clock edges since reset release; the edge with
  // index f*P is the boundary into frame f. A request sampled at edge s is
  // visible in frame f iff s <= f*P-2; latest such request wins.
  int         k = 0;
  int         m_e;
  int         m_a;
  int         req_s [3][$];
  int         req_w [3][$];
  int         exp_q [3][$];
  int         mwidth [3];
  logic [2:0] clamp_m = '0;
  logic [2:0] pend_m = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k       = 0;
      clamp_m = '0;
      pend_m  = '0;
      for (int ch = 0; ch < 3; ch++) begin
        req_s[ch].delete();
        req_w[ch].delete();
        exp_q[ch].delete();
        mwidth[ch] = W_RST;
        exp_q[ch].push_back(W_RST);
      end
    end else begin
      m_e = k + 1;
      k   = m_e;
      for (int ch = 0; ch < 3; ch++) begin
        if (vld[ch]) begin
          m_a = int'(ang[ch]);
          if (m_a > AMAX) begin
            clamp_m[ch] = 1'b1;
            m_a = AMAX;
          end
          req_s[ch].push_back(m_e);
          req_w[ch].push_back(PM + m_a * TPL);
        end
      end
      if (m_e % P == 0) begin
        for (int ch = 0; ch < 3; ch++) begin
          while (req_s[ch].size() > 0 && req_s[ch][0] <= m_e - 2) begin
            mwidth[ch] = req_w[ch][0];
            void'(req_s[ch].pop_front());
            void'(req_w[ch].pop_front());
          end
          exp_q[ch].push_back(mwidth[ch]);
        end
      end
      for (int ch = 0; ch < 3; ch++)
        pend_m[ch] = (req_s[ch].size() > 0 && req_s[ch][0] <= m_e - 1);
    end
  end

  // Monitor: measures each channel's pulse per frame and pops the prediction.
  int         hi_cnt [3];
  int         rises [3];
  int         w_exp;
  logic [2:0] prev = '0;
  bit         have_frame = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      have_frame = 1'b0;
      prev       = '0;
      for (int ch = 0; ch < 3; ch++) begin
        hi_cnt[ch] = 0;
        rises[ch]  = 0;
      end
    end else if (k > 0) begin
      check("frame_start", int'(frame_start), int'((k % P) == 1));
      check("pending", int'(pending), int'(pend_m));
      check("clamped", int'(clamped), int'(clamp_m));
      for (int ch = 0; ch < 3; ch++) begin
        if (frame_start) begin
          check($sformatf("pwm%0d_at_frame_start", ch), int'(pwm_w[ch]), 1);
          if (have_frame) begin
            if (exp_q[ch].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL sb_empty%0d: no prediction for completed frame (t=%0t)", ch, $time);
            end else begin
              w_exp = exp_q[ch].pop_front();
              check($sformatf("pwm%0d_width", ch), hi_cnt[ch], w_exp);
              check($sformatf("pwm%0d_pulses", ch), rises[ch], 1);
            end
          end
          hi_cnt[ch] = 0;
          rises[ch]  = 0;
        end
        if (pwm_w[ch]) begin
          hi_cnt[ch]++;
          if (!prev[ch]) rises[ch]++;
        end
      end
      if (frame_start) have_frame = 1'b1;
      prev = pwm_w;
    end
  end

  // Stimulus helpers: drive just after the falling edge.
  task automatic wait_phase(input int c);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((k % P) != c && n < 2 * P);
    if ((k % P) != c) begin
      tests++;
      fails++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", c, k % P);
    end
    #1;
  endtask

  task automatic pulse(input logic [2:0] m, input int a0, input int a1, input int a2);
    ang[0] = 12'(a0);
    ang[1] = 12'(a1);
    ang[2] = 12'(a2);
    vld    = m;
    @(negedge clock);
    #1;
    vld = '0;
  endtask

  function automatic int rand_angle();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(1801, 4095));
    return int'($urandom_range(0, 1800));
  endfunction

  initial begin
    ang[0] = '0;
    ang[1] = '0;
    ang[2] = '0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_pwm", int'(pwm_w), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_pending", int'(pending), 0);
    check("reset_clamped", int'(clamped), 0);
    reset_n = 1'b1;

    // Mid-frame update on all channels, then an out-of-range angle on channel 1.
    wait_phase(500);
    pulse(3'b111, 0, 1800, 450);
    wait_phase(503);
    check("pending_after_s2", int'(pending), 3'b111);
    wait_phase(700);
    pulse(3'b010, 0, 4000, 0);
    wait_phase(10);
    check("clamped_ch1_only", int'(clamped), 3'b010);

    // Last-writer-wins on channel 2; channel 0 written on the commit edge.
    wait_phase(1000);
    pulse(3'b100, 0, 0, 100);
    wait_phase(2000);
    pulse(3'b100, 0, 0, 1200);
    wait_phase(3998);
    pulse(3'b001, 200, 0, 0);
    wait_phase(5);
    check("pending0_across_boundary", int'(pending[0]), 1);
    wait_phase(3000);
    wait_phase(10);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 500)) @(negedge clock);
      #1;
      pulse(3'($urandom_range(1, 7)), rand_angle(), rand_angle(), rand_angle());
    end
    repeat (2 * P + 10) @(negedge clock);

    // Reset in the middle of a high pulse with a pending update.
    wait_phase(100);
    pulse(3'b001, 1800, 0, 0);
    wait_phase(50);
    pulse(3'b001, 0, 0, 0);
    wait_phase(300);
    check("pwm0_high_before_reset", int'(pwm0), 1);
    reset_n = 1'b0;
    #1;
    check("pwm_drop_on_reset", int'(pwm_w), 0);
    check("frame_start_on_reset", int'(frame_start), 0);
    repeat (3) @(negedge clock);
    #1;
    check("pending_in_reset", int'(pending), 0);
    check("clamped_in_reset", int'(clamped), 0);
    reset_n = 1'b1;
    wait_phase(2);
    check("pending_after_release", int'(pending), 0);
    check("clamped_after_release", int'(clamped), 0);
    repeat (3 * P + 10) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
